// File: rtl/grid_renderer_if.sv
// grid_renderer_if: game-controller display request in, VGA adapter pixel port out.
interface grid_renderer_if #(
  parameter int GRID_SIZE = 3,
  parameter int STATE_SIZE = 4
);
  localparam int N = GRID_SIZE * GRID_SIZE;
  logic d_enable;
  logic d_cursor;
  logic d_reveal;
  logic [1:0] wl;
  logic [N-1:0] bombGrid;
  logic [N-1:0] revealGrid;
  logic [N-1:0] cursorGrid;
  logic [STATE_SIZE*N-1:0] states;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot;
  logic busy;
  logic done;
  modport master (
    output d_enable, d_cursor, d_reveal, wl, bombGrid, revealGrid, cursorGrid, states,
    input x, y, colour, plot, busy, done
  );
  modport slave (
    input d_enable, d_cursor, d_reveal, wl, bombGrid, revealGrid, cursorGrid, states,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/grid_renderer.sv
// grid_renderer: snapshots the game grids and plots only changed cells, one pixel per clock.
// Optional macro CURSOR_BORDER_EN restricts the cursor colour to the cell border.
module grid_renderer #(
  parameter int GRID_SIZE = 3,
  parameter int STATE_SIZE = 4,
  parameter int CELL_PX = 8,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0
) (
  input logic clock,
  input logic reset,
  grid_renderer_if.slave io
);
  localparam int N = GRID_SIZE * GRID_SIZE;
  localparam int IW = $clog2(N + 1);
  localparam int GW = $clog2(GRID_SIZE + 1);
  localparam int PW = $clog2(CELL_PX);
  typedef enum logic [2:0] {IDLE, LATCH, SEEK, DRAW, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] bomb, rev, cur, mask, prev_cur, prev_rev;
  logic [STATE_SIZE*N-1:0] cnts;
  logic [STATE_SIZE-1:0] cnt;
  logic [1:0] wl_s, prev_wl;
  logic force_full, pending;
  logic [IW-1:0] idx;
  logic [GW-1:0] row, col;
  logic [PW-1:0] px, py;
  logic last_px, cell_end, seek_end, adv, cursor_on;
  logic [2:0] pix;
  logic unused;
  assign unused = &{1'b0, io.d_cursor, io.d_reveal};
  assign last_px = px == PW'(CELL_PX - 1);
  assign cell_end = last_px && py == PW'(CELL_PX - 1);
  assign seek_end = idx == IW'(N);
  assign adv = (state == SEEK && !seek_end && !mask[idx]) || (state == DRAW && cell_end);
  assign cnt = cnts[int'(idx)*STATE_SIZE +: STATE_SIZE];
`ifdef CURSOR_BORDER_EN
  assign cursor_on = cur[idx] && (px == '0 || py == '0 || last_px || py == PW'(CELL_PX - 1));
`else
  assign cursor_on = cur[idx];
`endif
  assign pix = cursor_on ? 3'b110 :
               (wl_s == 2'b10 && bomb[idx]) ? 3'b100 :
               !rev[idx] ? (wl_s == 2'b01 ? 3'b010 : 3'b001) :
               bomb[idx] ? 3'b100 :
               (cnt == '0) ? 3'b111 : 3'b011;
  assign io.busy = state != IDLE;
  assign io.done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = io.d_enable ? LATCH : IDLE;
      LATCH: state_n = SEEK;
      SEEK:  state_n = seek_end ? DONE : mask[idx] ? DRAW : SEEK;
      DRAW:  state_n = cell_end ? SEEK : DRAW;
      DONE:  state_n = (pending || io.d_enable) ? LATCH : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {bomb, rev, cur, mask, prev_cur, prev_rev, cnts, wl_s, prev_wl} <= '0;
      {pending, idx, row, col, px, py} <= '0;
      force_full <= 1'b1;
      io.x <= '0;
      io.y <= '0;
      io.colour <= '0;
      io.plot <= 1'b0;
    end else begin
      // requests during a frame coalesce; DONE consumes them
      pending <= (state == DONE) ? 1'b0 : pending | (io.d_enable && (state == SEEK || state == DRAW));
      io.plot <= state == DRAW;
      if (state == DRAW) begin
        io.x <= 8'(X_ORIGIN + int'(col) * CELL_PX + int'(px));
        io.y <= 7'(Y_ORIGIN + int'(row) * CELL_PX + int'(py));
        io.colour <= pix;
        px <= px + 1'b1;
        if (last_px) py <= py + 1'b1;
      end
      if (state == SEEK) begin
        px <= '0;
        py <= '0;
      end
      if (adv) begin
        idx <= idx + 1'b1;
        col <= (col == GW'(GRID_SIZE - 1)) ? '0 : col + 1'b1;
        if (col == GW'(GRID_SIZE - 1)) row <= row + 1'b1;
      end
      if (state == LATCH) begin
        bomb <= io.bombGrid;
        rev <= io.revealGrid;
        cur <= io.cursorGrid;
        cnts <= io.states;
        wl_s <= io.wl;
        mask <= (force_full || io.wl != prev_wl) ? '1 :
                (io.cursorGrid ^ prev_cur) | (io.revealGrid ^ prev_rev);
        {idx, row, col} <= '0;
      end
      if (state == DONE) begin
        prev_cur <= cur;
        prev_rev <= rev;
        prev_wl <= wl_s;
        force_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: directed frame vectors plus hand-written held/pending/reset sequences.
module tb_grid_renderer;
`ifdef CURSOR_BORDER_EN
  localparam int CUR_IN = 1;
`else
  localparam int CUR_IN = 6;
`endif
  typedef struct {
    logic [8:0] bomb, rev, cur;
    logic [1:0] wl;
    logic [35:0] st;
    int plots, drawn, cycles, fx, fy, ax, ay, ac, bx, by, bc;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  int cmp = 0, errs = 0;
  int plots = 0, bcyc = 0, dones = 0, drawn = 0, fx = 0, fy = 0;
  bit got_first = 0, busy_q = 0;
  logic [2:0] fb [0:255][0:127];
  vec_t v[6];
  grid_renderer_if #(.GRID_SIZE(3), .STATE_SIZE(4)) bus();
  grid_renderer dut (.clock(clk), .reset(rst_n), .io(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.busy && !busy_q) begin
      drawn = 0;
      got_first = 0;
    end
    busy_q = bus.busy;
    if (bus.busy) bcyc++;
    if (bus.done) dones++;
    if (bus.plot) begin
      if (!got_first) begin
        fx = int'(bus.x);
        fy = int'(bus.y);
        got_first = 1;
      end
      fb[bus.x][bus.y] = bus.colour;
      drawn |= 1 << (int'(bus.y) / 8 * 3 + int'(bus.x) / 8);
      plots++;
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  task automatic set_in(input logic [8:0] b, r, c, input logic [1:0] w, input logic [35:0] s);
    bus.bombGrid = b;
    bus.revealGrid = r;
    bus.cursorGrid = c;
    bus.wl = w;
    bus.states = s;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s idle", tag), int'(bus.busy), 0);
  endtask
  task automatic run_vec(input vec_t t, input string tag);
    int p0, b0, d0, n;
    @(negedge clk);
    set_in(t.bomb, t.rev, t.cur, t.wl, t.st);
    p0 = plots;
    b0 = bcyc;
    d0 = dones;
    bus.d_enable = 1;
    @(negedge clk);
    bus.d_enable = 0;
    n = 0;
    while (dones == d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk($sformatf("%s done", tag), dones - d0, 1);
    chk($sformatf("%s plots", tag), plots - p0, t.plots);
    chk($sformatf("%s cells", tag), drawn, t.drawn);
    chk($sformatf("%s cycles", tag), bcyc - b0, t.cycles);
    if (t.plots > 0) begin
      chk($sformatf("%s first_x", tag), fx, t.fx);
      chk($sformatf("%s first_y", tag), fy, t.fy);
    end
    chk($sformatf("%s pix(%0d,%0d)", tag, t.ax, t.ay), int'(fb[t.ax][t.ay]), t.ac);
    chk($sformatf("%s pix(%0d,%0d)", tag, t.bx, t.by), int'(fb[t.bx][t.by]), t.bc);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int p0, d0, b0, n;
    vec_t r6;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 128; j++) fb[i][j] = 3'b000;
    v[0] = '{9'h000, 9'h000, 9'h001, 2'b00, 36'h0,    576, 'h1FF, 588, 0, 0,  0,  0, 6,  3,  3, CUR_IN};
    v[1] = '{9'h000, 9'h000, 9'h002, 2'b00, 36'h0,    128, 'h003, 140, 0, 0,  3,  3, 1, 11,  3, CUR_IN};
    v[2] = '{9'h090, 9'h010, 9'h002, 2'b00, 36'h0,     64, 'h010,  76, 8, 8, 12, 12, 4, 12, 20, 1};
    v[3] = '{9'h090, 9'h010, 9'h002, 2'b10, 36'h0,    576, 'h1FF, 588, 0, 0, 12, 20, 4,  8,  0, 6};
    v[4] = '{9'h090, 9'h01C, 9'h002, 2'b01, 36'h3000, 576, 'h1FF, 588, 0, 0, 20,  4, 7,  4, 12, 3};
    v[5] = '{9'h090, 9'h01C, 9'h002, 2'b01, 36'h3000,   0, 'h000,  12, 0, 0, 12, 20, 2, 12, 12, 4};
    r6   = '{9'h090, 9'h01C, 9'h004, 2'b10, 36'h3000, 576, 'h1FF, 588, 0, 0, 12, 20, 4, 16,  0, 6};
    bus.d_enable = 0;
    bus.d_cursor = 0;
    bus.d_reveal = 0;
    set_in(9'h000, 9'h000, 9'h001, 2'b00, 36'h0);
    repeat (3) @(negedge clk);
    chk("reset plot", int'(bus.plot), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset xy", int'({bus.x, bus.y}), 0);
    chk("reset colour", int'(bus.colour), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) run_vec(v[i], $sformatf("vec%0d", i));
    // d_enable held high: one partial frame, then empty frames only
    @(negedge clk);
    set_in(9'h090, 9'h01C, 9'h004, 2'b01, 36'h3000);
    p0 = plots;
    d0 = dones;
    bus.d_enable = 1;
    repeat (700) @(negedge clk);
    bus.d_enable = 0;
    wait_idle("held");
    chk("held plots", plots - p0, 128);
    chk("held several frames", int'(dones - d0 > 2), 1);
    // three requests mid-frame coalesce into one empty follow-up frame
    @(negedge clk);
    set_in(9'h090, 9'h01C, 9'h004, 2'b00, 36'h3000);
    p0 = plots;
    d0 = dones;
    b0 = bcyc;
    bus.d_enable = 1;
    @(negedge clk);
    bus.d_enable = 0;
    repeat (100) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.d_enable = 1;
      @(negedge clk);
      bus.d_enable = 0;
      repeat (40) @(negedge clk);
    end
    wait_idle("pending");
    chk("pending plots", plots - p0, 576);
    chk("pending dones", dones - d0, 2);
    chk("pending cycles", bcyc - b0, 600);
    // reset at the 100th plot, then a forced full frame
    @(negedge clk);
    set_in(r6.bomb, r6.rev, r6.cur, r6.wl, r6.st);
    p0 = plots;
    bus.d_enable = 1;
    @(negedge clk);
    bus.d_enable = 0;
    n = 0;
    while (plots - p0 < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach 100 plots", plots - p0, 100);
    #1 rst_n = 0;
    #1;
    chk("midreset plot", int'(bus.plot), 0);
    chk("midreset busy", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    chk("midreset busy held", int'(bus.busy), 0);
    chk("midreset plot held", int'(bus.plot), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run_vec(r6, "after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
